calc_operand_fsm: RTL and testbench
===================================

Name: calc_operand_fsm

Overview:
- Upstream stage of the 4-digit decimal display: produces the 10-bit unsigned value that the display block renders.
- Debounces two push-buttons, collects operand A and operand B from slide switches, and executes the selected add/sub/mul/div operation.
- Presents the live switch value during entry and the registered result afterwards, with an error flag.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required before a button level is accepted (sim: 4).
- WIDTH, 10, operand/result width; MAX_VAL = 2**WIDTH-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sw  in  WIDTH  operand switches
- op  in  2  operation select: 0 add, 1 sub, 2 mul, 3 div; sampled on B entry
- btn_enter  in  1  raw enter button, asynchronous and bouncy
- btn_clear  in  1  raw clear button, asynchronous and bouncy
- value  out  WIDTH  number to display, registered
- err  out  1  result invalid (overflow, negative, divide by zero)
- busy  out  1  high while in CALC
- phase  out  2  current state encoding, for LEDs

Behaviour:
- Reset, synchronous and dominant:
  - state=ENTER_A
  - a=0, b=0, op_q=0
  - value=0, err=0, busy=0
  - debouncers cleared to level 0 with no pulse pending
- Button conditioning, per button:
  - 2-flop synchronizer, then stability counter.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive samples differing from the current level.
  - Any glitch restarts the count.
  - A 1-cycle pulse is emitted on each debounced 0->1 transition; there is no pulse on release.
  - Latency from a stable raw edge to the pulse is DEBOUNCE_CYCLES+2 cycles.
- States: ENTER_A, ENTER_B, CALC, RESULT.
- ENTER_A:
  - value<=sw every cycle (1-cycle latency).
  - On enter pulse: a<=sw, go to ENTER_B.
- ENTER_B:
  - value<=sw every cycle.
  - On enter pulse: b<=sw, op_q<=op, go to CALC.
- CALC, busy=1:
  - add: result = a+b, computed in WIDTH+1 bits; >MAX_VAL -> err=1, value=MAX_VAL.
  - sub: a<b -> err=1, value=0; else value=a-b.
  - mul: full 2*WIDTH-bit product; >MAX_VAL -> err=1, value=MAX_VAL.
  - add/sub/mul take 1 cycle in CALC, then go to RESULT.
  - div:
    - b==0 -> err=1, value=MAX_VAL after 1 cycle.
    - Otherwise a restoring divider producing 1 quotient bit per cycle: WIDTH cycles in CALC, then value=quotient, remainder discarded, err=0.
  - Enter pulses during CALC are ignored.
- RESULT: value and err held.
  - Enter pulse with err=0: a<=value (chaining), go to ENTER_B.
  - Enter pulse with err=1: err<=0, go to ENTER_A.
- Clear pulse, any state, including mid-division:
  - a=b=0, err=0, go to ENTER_A next cycle.
  - Clear has priority over a simultaneous enter.
- err is cleared on any transition into ENTER_A or ENTER_B.
- phase encoding: 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 RESULT.
- Op codes outside the enumeration cannot occur (2-bit, all four defined).

Decomposition:
- Package calc_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - state_t enum (ENTER_A, ENTER_B, CALC, RESULT)
  - WIDTH and MAX_VAL constants
- Sub-module btn_debounce (synchronizer, counter, level, rise pulse), instantiated for enter and clear.
- Divider kept inline in the FSM.

Test Plan (DEBOUNCE_CYCLES=4):
- Debounce: raw enter glitch high for 3 cycles -> no pulse, stays ENTER_A. Held for 10 cycles -> exactly one pulse, phase=1.
- Add: a=500, b=300 -> value=800, err=0. Add a=1000, b=100 -> value=1023, err=1.
- Sub / mul:
  - Sub 5-9 -> value=0, err=1.
  - Mul 31*33 -> value=1023, err=0.
  - Mul 32*32 -> value=1023, err=1.
- Div:
  - 1000/7 -> busy high exactly 10 cycles, then value=142, err=0.
  - 17/0 -> value=1023, err=1 after 1 CALC cycle.
- Chaining and clear:
  - Result 800, then enter, then b=23 with op add -> value=823.
  - Clear asserted together with enter during a division -> phase=0, err=0, busy=0, value tracks sw next cycle.
- Reset: rst pulsed in RESULT with value=823 -> next cycle value=0, err=0, phase=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand/result stage.
// Operand width is fixed here so every block agrees on it.
`timescale 1ns/1ps
package calc_pkg;

    localparam int WIDTH = 10;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(2**WIDTH - 1);

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        RESULT  = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a single-cycle pulse on each accepted press.
`timescale 1ns/1ps
module btn_debounce #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            // Any sample matching the current level restarts the count.
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(CYCLES - 1)) begin
                    level_q <= sync2_q;
                    pulse_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/calc_operand_fsm.sv
// Operand entry and arithmetic FSM feeding the 4-digit display.
// Division is a restoring divider, one quotient bit per CALC cycle.
`timescale 1ns/1ps
module calc_operand_fsm
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] value,
    output logic             err,
    output logic             busy,
    output logic [1:0]       phase
);

    localparam int SW_ = $clog2(WIDTH);

    logic enter_pulse;
    logic clr_pulse;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_enter),
        .pulse_o (enter_pulse)
    );

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_clear),
        .pulse_o (clr_pulse)
    );

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [SW_-1:0]   step_q, step_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   trial;
    logic               fits;
    logic [WIDTH-1:0]   quo_next;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        value_d = value_q;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        step_d  = step_q;

        sum      = {1'b0, a_q} + {1'b0, b_q};
        prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        // Partial remainder never exceeds b, so the low bits of the
        // difference are exact whenever the trial subtraction fits.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = shifted >= {1'b0, b_q};
        trial    = shifted[WIDTH-1:0] - b_q;
        quo_next = {quo_q[WIDTH-2:0], fits};

        if (clr_pulse) begin
            a_d     = '0;
            b_d     = '0;
            err_d   = 1'b0;
            value_d = sw;
            state_d = ENTER_A;
        end else begin
            unique case (state_q)
                ENTER_A: begin
                    value_d = sw;
                    if (enter_pulse) begin
                        a_d     = sw;
                        err_d   = 1'b0;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    value_d = sw;
                    if (enter_pulse) begin
                        b_d     = sw;
                        op_d    = op_t'(op);
                        rem_d   = '0;
                        quo_d   = a_q;
                        step_d  = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    unique case (op_q)
                        OP_ADD: begin
                            err_d   = sum[WIDTH];
                            value_d = sum[WIDTH] ? MAX_VAL : sum[WIDTH-1:0];
                            state_d = RESULT;
                        end
                        OP_SUB: begin
                            err_d   = a_q < b_q;
                            value_d = (a_q < b_q) ? '0 : a_q - b_q;
                            state_d = RESULT;
                        end
                        OP_MUL: begin
                            err_d   = prod > {{WIDTH{1'b0}}, MAX_VAL};
                            value_d = err_d ? MAX_VAL : prod[WIDTH-1:0];
                            state_d = RESULT;
                        end
                        OP_DIV: begin
                            if (b_q == '0) begin
                                err_d   = 1'b1;
                                value_d = MAX_VAL;
                                state_d = RESULT;
                            end else begin
                                quo_d  = quo_next;
                                rem_d  = fits ? trial : shifted[WIDTH-1:0];
                                step_d = step_q + 1'b1;
                                if (step_q == SW_'(WIDTH - 1)) begin
                                    err_d   = 1'b0;
                                    value_d = quo_next;
                                    state_d = RESULT;
                                end
                            end
                        end
                    endcase
                end
                RESULT: begin
                    if (enter_pulse) begin
                        err_d = 1'b0;
                        if (err_q) begin
                            state_d = ENTER_A;
                        end else begin
                            a_d     = value_q;
                            state_d = ENTER_B;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTER_A;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            value_q <= value_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            step_q  <= step_d;
        end
    end

    assign value = value_q;
    assign err   = err_q;
    assign busy  = (state_q == CALC);
    assign phase = state_q;

endmodule

// File: tb/tb_calc_operand_fsm.sv
// Directed bench for calc_operand_fsm with a 4-sample debounce.
// Inputs change and outputs are checked on the falling clock edge.
`timescale 1ns/1ps
module tb_calc_operand_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw;
    logic [1:0] op;
    logic       btn_enter;
    logic       btn_clear;
    logic [9:0] value;
    logic       err;
    logic       busy;
    logic [1:0] phase;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles = 0;
    int enter_seen  = 0;

    calc_operand_fsm #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .op        (op),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .value     (value),
        .err       (err),
        .busy      (busy),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (dut.enter_pulse === 1'b1) enter_seen++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_phase(input int p, input string tag);
        int n = 0;
        while (phase !== 2'(p) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(phase), p);
    endtask

    initial begin
        int p0;
        int b0;
        rst       = 1'b1;
        sw        = '0;
        op        = 2'd0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", int'(value), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_phase", int'(phase), 0);
        rst = 1'b0;

        sw = 10'd5;
        @(negedge clk);
        check("live_sw", int'(value), 5);

        // Short glitch must not register as a press.
        p0 = enter_seen;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_phase", int'(phase), 0);
        check("glitch_pulses", enter_seen - p0, 0);

        sw = 10'd500;
        p0 = enter_seen;
        press_enter();
        check("held_pulses", enter_seen - p0, 1);
        check("held_phase", int'(phase), 1);
        sw = 10'd300;
        op = 2'd0;
        press_enter();
        check("add_phase", int'(phase), 3);
        check("add_value", int'(value), 800);
        check("add_err", int'(err), 0);

        press_enter();
        check("chain_phase", int'(phase), 1);
        sw = 10'd23;
        press_enter();
        check("chain_value", int'(value), 823);
        check("chain_err", int'(err), 0);

        rst = 1'b1;
        @(negedge clk);
        check("rst2_value", int'(value), 0);
        check("rst2_err", int'(err), 0);
        check("rst2_phase", int'(phase), 0);
        rst = 1'b0;

        sw = 10'd1000;
        press_enter();
        sw = 10'd100;
        op = 2'd0;
        press_enter();
        check("addovf_value", int'(value), 1023);
        check("addovf_err", int'(err), 1);
        press_enter();
        check("errack_phase", int'(phase), 0);
        check("errack_err", int'(err), 0);

        sw = 10'd5;
        press_enter();
        sw = 10'd9;
        op = 2'd1;
        press_enter();
        check("sub_value", int'(value), 0);
        check("sub_err", int'(err), 1);
        press_enter();

        sw = 10'd31;
        press_enter();
        sw = 10'd33;
        op = 2'd2;
        press_enter();
        check("mul_value", int'(value), 1023);
        check("mul_err", int'(err), 0);
        press_clear();
        check("clr_phase", int'(phase), 0);

        sw = 10'd32;
        press_enter();
        sw = 10'd32;
        op = 2'd2;
        press_enter();
        check("mulovf_value", int'(value), 1023);
        check("mulovf_err", int'(err), 1);
        press_enter();

        sw = 10'd1000;
        press_enter();
        sw = 10'd7;
        op = 2'd3;
        b0 = busy_cycles;
        press_enter();
        check("div_busy", busy_cycles - b0, 10);
        check("div_value", int'(value), 142);
        check("div_err", int'(err), 0);
        press_clear();

        sw = 10'd17;
        press_enter();
        sw = 10'd0;
        b0 = busy_cycles;
        press_enter();
        check("div0_busy", busy_cycles - b0, 1);
        check("div0_value", int'(value), 1023);
        check("div0_err", int'(err), 1);
        press_enter();

        // Clear while enter is held and a division is underway.
        sw = 10'd1000;
        press_enter();
        sw = 10'd7;
        btn_enter = 1'b1;
        wait_phase(2, "middiv_calc");
        btn_clear = 1'b1;
        wait_phase(0, "middiv_phase");
        check("middiv_busy", int'(busy), 0);
        check("middiv_err", int'(err), 0);
        sw = 10'd77;
        @(negedge clk);
        check("middiv_value", int'(value), 77);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);

        // Simultaneous press pulses: clear must win.
        sw = 10'd3;
        press_enter();
        p0 = enter_seen;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        check("both_pulses", enter_seen - p0, 1);
        check("both_phase", int'(phase), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
